// File: rtl/acc_avg_pkg.sv
// acc_avg_pkg: shared defaults and helpers for the acc_avg_2n block averager.
//   R_DEF    : default input/mean sample width
//   NMAX_DEF : default maximum log2 block length
//   NW_DEF   : default width of the n_sel / n_cur fields
//   SW_DEF   : default accumulator / sum width (R + NMAX)
//   phase_e  : start-up phase (first edge after reset latches n_sel)
//   clamp_n  : limit a requested log2 length to the supported maximum
package acc_avg_pkg;

  localparam int R_DEF    = 14;
  localparam int NMAX_DEF = 10;
  localparam int NW_DEF   = 4;
  localparam int SW_DEF   = R_DEF + NMAX_DEF;

  typedef enum logic {
    PH_LATCH = 1'b0,
    PH_RUN   = 1'b1
  } phase_e;

  function automatic int unsigned clamp_n(input int unsigned n, input int unsigned nmax);
    return (n > nmax) ? nmax : n;
  endfunction

endpackage

// File: rtl/acc_avg_2n_avg_scale.sv
// avg_scale: combinational divide-by-2**shift of a block sum.
//   sum_in : signed block sum, R+NMAX bits
//   shift  : log2 block length in force for the block
//   mean   : signed mean, R bits
// Build option ACC_AVG_ROUND_EN: round half up and saturate to the R-bit
// range; otherwise a plain arithmetic shift (truncation toward -inf).
module avg_scale #(
  parameter int R    = 14,
  parameter int NMAX = 10,
  parameter int NW   = 4
) (
  input  logic signed [R+NMAX-1:0] sum_in,
  input  logic        [NW-1:0]     shift,
  output logic signed [R-1:0]      mean
);

  localparam int SW = R + NMAX;

`ifdef ACC_AVG_ROUND_EN
  // One extra bit of headroom so adding the rounding term cannot wrap.
  localparam logic signed [SW:0] MAXV = {{(SW-R+2){1'b0}}, {(R-1){1'b1}}};
  localparam logic signed [SW:0] MINV = {{(SW-R+2){1'b1}}, {(R-1){1'b0}}};

  logic signed [SW:0] ext;
  logic signed [SW:0] bias;
  logic signed [SW:0] rnd;
  logic signed [SW:0] shf;

  always_comb begin
    ext  = {sum_in[SW-1], sum_in};
    bias = '0;
    if (shift != '0)
      bias = (SW+1)'(1) << (shift - NW'(1));
    rnd  = ext + bias;
    shf  = rnd >>> shift;
    if (shf > MAXV)
      mean = R'(MAXV);
    else if (shf < MINV)
      mean = R'(MINV);
    else
      mean = R'(shf);
  end
`else
  always_comb begin
    mean = R'(sum_in >>> shift);
  end
`endif

endmodule

// File: rtl/acc_avg_2n.sv
// acc_avg_2n: run-time configurable block averager. Accumulates 2**n_cur
// qualified signed samples, then publishes sum and mean with a one-cycle
// out_valid strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : signed sample (R bits), accepted when in_valid is high
//   n_sel      : requested log2 block length, latched at block boundaries,
//                on clr, and on the first edge after reset (clamped to NMAX)
//   clr        : synchronous clear of the partial block
//   sum, mean  : results of the last completed block
//   out_valid  : one-cycle strobe when sum/mean update
//   n_cur      : log2 length in force for the current block
//   cnt        : samples accumulated in the current block
// Build option ACC_AVG_ROUND_EN selects rounding/saturating mean (see avg_scale).
module acc_avg_2n
  import acc_avg_pkg::*;
#(
  parameter int R    = R_DEF,
  parameter int NMAX = NMAX_DEF,
  parameter int NW   = NW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [R-1:0]      in,
  input  logic                     in_valid,
  input  logic        [NW-1:0]     n_sel,
  input  logic                     clr,
  output logic signed [R+NMAX-1:0] sum,
  output logic signed [R-1:0]      mean,
  output logic                     out_valid,
  output logic        [NW-1:0]     n_cur,
  output logic        [NMAX:0]     cnt
);

  localparam int SW = R + NMAX;

  phase_e ph, ph_nxt;

  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] acc_nxt;
  logic        [NMAX:0] cnt_inc;
  logic        [NMAX:0] blk_len;
  logic        [NW-1:0] n_sel_cl;
  logic        [NW-1:0] n_eff;
  logic                 done;
  logic signed [R-1:0]  mean_calc;

  // On the latch edge n_cur still holds its reset value, so the freshly
  // clamped n_sel governs any sample accepted on that same edge.
  always_comb begin
    ph_nxt   = PH_RUN;
    n_sel_cl = NW'(clamp_n(32'(n_sel), NMAX));
    n_eff    = (ph == PH_LATCH) ? n_sel_cl : n_cur;
    acc_nxt  = acc + {{NMAX{in[R-1]}}, in};
    cnt_inc  = cnt + (NMAX+1)'(1);
    blk_len  = (NMAX+1)'(1) << n_eff;
    done     = in_valid && !clr && (cnt_inc == blk_len);
  end

  avg_scale #(
    .R    (R),
    .NMAX (NMAX),
    .NW   (NW)
  ) u_scale (
    .sum_in (acc_nxt),
    .shift  (n_eff),
    .mean   (mean_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ph <= PH_LATCH;
    else
      ph <= ph_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sum       <= '0;
      mean      <= '0;
      out_valid <= 1'b0;
      n_cur     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (ph == PH_LATCH)
        n_cur <= n_sel_cl;
      if (clr) begin
        acc   <= '0;
        cnt   <= '0;
        n_cur <= n_sel_cl;
      end else if (in_valid) begin
        if (done) begin
          sum       <= acc_nxt;
          mean      <= mean_calc;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          n_cur     <= n_sel_cl;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_avg_2n.sv
// tb_acc_avg_2n: directed, table-driven bench for acc_avg_2n with default
// parameters (R=14, NMAX=10, NW=4), plus hand-written multi-cycle sequences
// for clear, full-length block, rounding and asynchronous reset.
module tb_acc_avg_2n;

  localparam int R    = 14;
  localparam int NMAX = 10;
  localparam int NW   = 4;

  logic                     clk;
  logic                     rst_n;
  logic signed [R-1:0]      in_s;
  logic                     in_valid;
  logic        [NW-1:0]     n_sel;
  logic                     clr;
  logic signed [R+NMAX-1:0] sum;
  logic signed [R-1:0]      mean;
  logic                     out_valid;
  logic        [NW-1:0]     n_cur;
  logic        [NMAX:0]     cnt;

  int n_pass  = 0;
  int n_total = 0;

  acc_avg_2n #(.R(R), .NMAX(NMAX), .NW(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_s),
    .in_valid  (in_valid),
    .n_sel     (n_sel),
    .clr       (clr),
    .sum       (sum),
    .mean      (mean),
    .out_valid (out_valid),
    .n_cur     (n_cur),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int in;
    bit iv;
    int nsel;
    bit clr;
    bit eov;
    int esum;
    int emt;   // expected mean, truncating build
    int emr;   // expected mean, rounding build
    int ecnt;
    int encur;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int i, bit iv, int ns, bit c, bit eov, int es,
                              int emt, int emr, int ec, int enc);
    vec_t v;
    v.in = i; v.iv = iv; v.nsel = ns; v.clr = c; v.eov = eov; v.esum = es;
    v.emt = emt; v.emr = emr; v.ecnt = ec; v.encur = enc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_all(input string tag, input bit eov, input longint es,
                           input longint emt, input longint emr,
                           input longint ec, input longint enc);
    check({tag, ".out_valid"}, longint'(out_valid), longint'(eov));
    check({tag, ".sum"}, longint'(sum), es);
`ifdef ACC_AVG_ROUND_EN
    check({tag, ".mean"}, longint'(mean), emr);
`else
    check({tag, ".mean"}, longint'(mean), emt);
`endif
    check({tag, ".cnt"}, longint'(cnt), ec);
    check({tag, ".n_cur"}, longint'(n_cur), enc);
  endtask

  task automatic drive(input int i, input bit iv, input int ns, input bit c);
    @(negedge clk);
    in_s     = R'(i);
    in_valid = iv;
    n_sel    = NW'(ns);
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ov_seen;

    // Per-cycle vectors: stimulus, then state expected after that edge.
    add(0, 0, 2, 0, 0, 0, 0, 0, 0, 2);             // latch edge
    add(5, 1, 2, 0, 0, 0, 0, 0, 1, 2);
    add(5, 1, 2, 0, 0, 0, 0, 0, 2, 2);
    add(5, 1, 2, 0, 0, 0, 0, 0, 3, 2);
    add(5, 1, 3, 0, 1, 20, 5, 5, 0, 3);            // block done, n_sel=3 latched
    add(0, 0, 3, 0, 0, 20, 5, 5, 0, 3);
    for (int k = 1; k <= 7; k++)
      add(-3, 1, 3, 0, 0, 20, 5, 5, k, 3);
    add(-3, 1, 2, 0, 1, -24, -3, -3, 0, 2);
    add(-1, 1, 2, 0, 0, -24, -3, -3, 1, 2);
    add(0, 1, 2, 0, 0, -24, -3, -3, 2, 2);
    add(0, 1, 2, 0, 0, -24, -3, -3, 3, 2);
    add(0, 1, 1, 0, 1, -1, -1, 0, 0, 1);           // -1/4: trunc -1, round 0
    add(7, 1, 1, 0, 0, -1, -1, 0, 1, 1);           // alternating in_valid
    add(0, 0, 1, 0, 0, -1, -1, 0, 1, 1);
    add(9, 1, 1, 0, 1, 16, 8, 8, 0, 1);
    add(0, 0, 1, 0, 0, 16, 8, 8, 0, 1);
    add(11, 1, 3, 0, 0, 16, 8, 8, 1, 1);           // n_sel changes mid-block
    add(0, 0, 3, 0, 0, 16, 8, 8, 1, 1);
    add(-4, 1, 3, 0, 1, 7, 3, 4, 0, 3);            // still 2 samples; then 8
    for (int k = 1; k <= 7; k++)
      add(1, 1, 3, 0, 0, 7, 3, 4, k, 3);
    add(1, 1, 0, 0, 1, 8, 1, 1, 0, 0);
    add(100, 1, 0, 0, 1, 100, 100, 100, 0, 0);     // n_cur=0: mean follows in
    add(-7, 1, 0, 0, 1, -7, -7, -7, 0, 0);
    add(3, 1, 0, 0, 1, 3, 3, 3, 0, 0);
    add(0, 0, 0, 0, 0, 3, 3, 3, 0, 0);

    // Reset state
    rst_n = 1'b0; in_s = '0; in_valid = 1'b0; n_sel = NW'(2); clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].in, vecs[i].iv, vecs[i].nsel, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].eov, vecs[i].esum,
                vecs[i].emt, vecs[i].emr, vecs[i].ecnt, vecs[i].encur);
    end

    // clr on the completing sample's edge, with an out-of-range n_sel
    drive(0, 0, 1, 1);
    check_all("clr_relatch", 0, 3, 3, 3, 0, 1);
    drive(10, 1, 1, 0);
    check_all("clr_part", 0, 3, 3, 3, 1, 1);
    drive(20, 1, 15, 1);
    check_all("clr_win", 0, 3, 3, 3, 0, NMAX);

    // Full-length block of maximum positive samples
    ov_seen = 0;
    for (int k = 0; k < 1023; k++) begin
      drive(8191, 1, 15, 0);
      if (out_valid) ov_seen++;
    end
    check("max_no_early_ov", longint'(ov_seen), 0);
    check("max_cnt", longint'(cnt), 1023);
    drive(8191, 1, 2, 0);
    check_all("max_blk", 1, 8191 * 1024, 8191, 8191, 0, 2);

    // 8190.75 average: truncates to 8190, rounds to 8191
    drive(8191, 1, 2, 0);
    drive(8191, 1, 2, 0);
    drive(8191, 1, 2, 0);
    drive(8190, 1, 2, 0);
    check_all("round_hi", 1, 32763, 8190, 8191, 0, 2);

    // Asynchronous reset mid-block
    drive(5, 1, 2, 0);
    drive(6, 1, 2, 0);
    check("pre_rst_cnt", longint'(cnt), 2);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_sel = NW'(1);
    rst_n = 1'b1;
    drive(3, 1, 1, 0);
    check_all("post_rst1", 0, 0, 0, 0, 1, 1);
    drive(4, 1, 1, 0);
    check_all("post_rst2", 1, 7, 3, 4, 0, 1);
    drive(0, 0, 1, 0);
    check("post_rst_ov_drop", longint'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/acc_avg_2n.md
# acc_avg_2n

Runtime-configurable block averager: accumulates 2**n qualified signed input samples, then publishes their sum and mean and pulses a valid strobe. It generalises the team's fixed-length sum/mean block with an input qualifier, an averaging length selectable at run time, synchronous clear, correct sign extension and optional rounding. It sits between ADC/demodulator data paths and the register bank or slower loop-filter logic.

## Interface
- R, 14: input/mean sample width (signed).
- NMAX, 10: maximum log2 block length; n_sel range 0..NMAX.
- NW, 4: width of n_sel; must satisfy 2**NW > NMAX.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset; release synchronised externally.
- in  in  R  signed input sample.
- in_valid  in  1  sample qualifier; sample accepted on clk edge where high.
- n_sel  in  NW  requested log2 block length; latched only at block boundaries or on clr.
- clr  in  1  synchronous clear: drop partial block, re-latch n_sel.
- sum  out  R+NMAX  signed sum of last completed block.
- mean  out  R  signed mean of last completed block.
- out_valid  out  1  one-cycle pulse when sum/mean update.
- n_cur  out  NW  log2 length in force for the current block.
- cnt  out  NMAX+1  valid samples accumulated in current block.

## Operation
- Reset: sum=0, mean=0, out_valid=0, cnt=0, accumulator=0, n_cur=min(n_sel,NMAX) sampled at first clk after reset release (n_cur=0 while in reset).
- n_sel > NMAX clamped to NMAX when latched.
- Each accepted sample: acc += sign-extend(in) to R+NMAX bits; cnt += 1.
- Block completes when accepted sample makes cnt reach 2**n_cur. On that edge: sum <= acc + in (full block), mean <= scale(full block), out_valid <= 1, acc <= 0, cnt <= 0, n_cur <= clamped n_sel.
- No sample lost at boundary: the completing sample belongs to the finishing block; the next accepted sample starts the new block.
- scale: arithmetic right shift by n_cur (truncation toward -inf); n_cur=0 gives mean=in.
- sum/mean hold until next completion; out_valid low otherwise.
- clr high: acc <= 0, cnt <= 0, n_cur <= clamped n_sel, out_valid <= 0; in ignored that cycle; sum/mean retain old values. clr wins over a simultaneous completing sample (no output).
- Accumulator cannot overflow: 2**NMAX samples of R bits fit in R+NMAX bits.
- State machine is implicit: ACCUM (cnt<2**n_cur) with single-edge COMMIT action; no idle state.

## Timing
- Latency: last sample of a block accepted at edge k -> sum/mean/out_valid visible after edge k (registered, one cycle), out_valid deasserts after edge k+1 unless another block completes (possible only when n_cur=0).
- n_cur=0 with in_valid held high: out_valid high continuously, mean follows in with one-cycle delay.
- Throughput: one sample per clock, back-to-back blocks with no gap.
- n_sel change mid-block takes effect from the next block only.
- Asynchronous reset mid-block discards all state immediately.

## Configuration
- ACC_AVG_ROUND_EN defined: mean = (sum + 2**(n_cur-1)) >>> n_cur (round half up), saturated to [-2**(R-1), 2**(R-1)-1]; n_cur=0 no rounding term. sum unaffected.
- Not defined: plain truncating arithmetic shift, no saturation logic (result always in range).

## Structure
- Package acc_avg_pkg: default R/NMAX/NW localparams, clamp function for n_sel, R+NMAX width constant.
- One sub-module: avg_scale (combinational shift, optional round and saturate, selected by ACC_AVG_ROUND_EN); accumulator, counter and commit logic stay in acc_avg_2n.

## Test plan
- Reset then n_sel=2, in=+5 valid 4 cycles -> one out_valid pulse, sum=20, mean=5, cnt back to 0.
- n_sel=3, in=-3 x8 -> sum=-24, mean=-3; sequence -1,0,0,0 with n_sel=2 -> sum=-1, mean=-1 (truncate) or 0 (ACC_AVG_ROUND_EN).
- R=14, n_sel=NMAX, in=8191 continuous -> sum=8191*1024, no overflow; with ACC_AVG_ROUND_EN input 8191,8191,8191,8190 n_sel=2 -> mean=8191 (round 8190.75 up, no saturation needed).
- in_valid toggled 1-0-1-0..., n_sel=1 -> out_valid every 4 clocks, sums correct; n_sel changed to 3 mid-block -> current block completes at 2 samples, next needs 8.
- clr asserted on the completing sample's edge -> no out_valid, sum/mean unchanged, cnt=0; n_sel=15 latched -> n_cur=NMAX.
- rst_n pulsed low mid-block -> all outputs 0 immediately, next block counts from zero.
